// File: rtl/disk_arbiter.sv
// Round-robin arbiter sharing one sdhd disk emulator between RF11 (ch0) and RK11 (ch1).
// Optional operation watchdog enabled with `define DISK_ARB_TIMEOUT_EN.
module disk_arbiter #(
  parameter int unsigned SYS_FRQ    = 27_000_000,
  parameter int unsigned TIMEOUT_MS = 2000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_cmd0,
  input  logic [1:0]  i_cmd1,
  input  logic [23:0] i_blk0,
  input  logic [23:0] i_blk1,
  input  logic [15:0] i_dma0,
  input  logic [15:0] i_dma1,
  input  logic [15:0] i_wc0,
  input  logic [15:0] i_wc1,
  output logic [1:0]  o_done,
  output logic [1:0]  o_err,
  output logic        o_busy,
  output logic        o_owner,
  output logic        o_disk_read,
  output logic        o_disk_write,
  output logic        o_disk_seek,
  output logic [23:0] o_disk_block_address,
  output logic [15:0] o_dma_start_address,
  output logic [15:0] o_dma_wordcount,
  input  logic        i_disk_ready,
  input  logic [3:0]  i_sd_error
);

  localparam int unsigned BLK_W = 24;
  localparam int unsigned ADR_W = 16;
  localparam logic [1:0] CMD_RD = 2'b01;
  localparam logic [1:0] CMD_WR = 2'b10;
  localparam logic [1:0] CMD_SK = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

  state_t             r_state, w_state_n;
  logic               r_rr, w_rr_n;
  logic               r_fault, w_fault_n;
  logic               r_owner, w_owner_n;
  logic               r_busy, w_busy_n;
  logic [1:0]         r_cmd, w_cmd_n;
  logic [BLK_W-1:0]   r_blk, w_blk_n;
  logic [ADR_W-1:0]   r_dma, w_dma_n;
  logic [ADR_W-1:0]   r_wc, w_wc_n;
  logic [1:0]         r_done, w_done_n;
  logic [1:0]         r_err, w_err_n;
  logic               r_rd, w_rd_n;
  logic               r_wr, w_wr_n;
  logic               r_sk, w_sk_n;
  logic               w_grant;
  logic               w_fin;
  logic               w_fin_err;
  logic               w_drive;
  logic [1:0]         w_lvl_cmd;

`ifdef DISK_ARB_TIMEOUT_EN
  localparam int unsigned TMO_LIMIT = SYS_FRQ / 1000 * TIMEOUT_MS;
  logic [31:0] r_tmo, w_tmo_n;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_tmo <= '0;
    else            r_tmo <= w_tmo_n;
  end
`else
  logic [31:0] w_unused_cfg;
  assign w_unused_cfg = 32'(SYS_FRQ) ^ 32'(TIMEOUT_MS);
`endif

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_fault <= 1'b0;
      r_owner <= 1'b0;
      r_busy  <= 1'b0;
      r_cmd   <= '0;
      r_blk   <= '0;
      r_dma   <= '0;
      r_wc    <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_sk    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_rr    <= w_rr_n;
      r_fault <= w_fault_n;
      r_owner <= w_owner_n;
      r_busy  <= w_busy_n;
      r_cmd   <= w_cmd_n;
      r_blk   <= w_blk_n;
      r_dma   <= w_dma_n;
      r_wc    <= w_wc_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
      r_rd    <= w_rd_n;
      r_wr    <= w_wr_n;
      r_sk    <= w_sk_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_n = r_state;
    w_rr_n    = r_rr;
    w_fault_n = r_fault;
    w_owner_n = r_owner;
    w_busy_n  = r_busy;
    w_cmd_n   = r_cmd;
    w_blk_n   = r_blk;
    w_dma_n   = r_dma;
    w_wc_n    = r_wc;
    w_done_n  = '0;
    w_err_n   = '0;
    w_fin     = 1'b0;
    w_fin_err = 1'b0;
    w_drive   = 1'b0;
    w_lvl_cmd = r_cmd;
    w_grant   = i_req[r_rr] ? r_rr : ~r_rr;
`ifdef DISK_ARB_TIMEOUT_EN
    w_tmo_n   = r_tmo;
`endif

    case (r_state)
      S_IDLE: begin
        // A dead emulator never raises ready, so fault mode grants regardless
        if ((|i_req) && (i_disk_ready || r_fault)) begin
          w_owner_n = w_grant;
          w_busy_n  = 1'b1;
          w_cmd_n   = w_grant ? i_cmd1 : i_cmd0;
          w_blk_n   = w_grant ? i_blk1 : i_blk0;
          w_dma_n   = w_grant ? i_dma1 : i_dma0;
          w_wc_n    = w_grant ? i_wc1  : i_wc0;
`ifdef DISK_ARB_TIMEOUT_EN
          w_tmo_n   = '0;
`endif
          if (r_fault || (w_cmd_n == 2'b00)) begin
            w_fin     = 1'b1;
            w_fin_err = 1'b1;
          end else begin
            w_state_n = S_ISSUE;
            w_drive   = 1'b1;
            w_lvl_cmd = w_cmd_n;
          end
        end
      end
      S_ISSUE: begin
        if (!i_disk_ready) w_state_n = S_BUSY;
        else               w_drive   = 1'b1;
      end
      S_BUSY: begin
        if (i_disk_ready) begin
          w_fin = 1'b1;
        end else if (i_sd_error != 4'd0) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
          w_fault_n = 1'b1;
        end
      end
      S_DONE: begin
        w_rr_n    = ~r_owner;
        w_busy_n  = 1'b0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase

`ifdef DISK_ARB_TIMEOUT_EN
    if ((r_state == S_ISSUE) || (r_state == S_BUSY)) begin
      if ((r_tmo + 32'd1) >= 32'(TMO_LIMIT)) begin
        w_drive   = 1'b0;
        w_fin     = 1'b1;
        w_fin_err = 1'b1;
        w_fault_n = 1'b1;
      end else begin
        w_tmo_n = r_tmo + 32'd1;
      end
    end
`endif

    if (w_fin) begin
      w_state_n            = S_DONE;
      w_done_n[w_owner_n]  = 1'b1;
      w_err_n[w_owner_n]   = w_fin_err;
    end

    w_rd_n = w_drive && (w_lvl_cmd == CMD_RD);
    w_wr_n = w_drive && (w_lvl_cmd == CMD_WR);
    w_sk_n = w_drive && (w_lvl_cmd == CMD_SK);
  end

  assign o_done               = r_done;
  assign o_err                = r_err;
  assign o_busy               = r_busy;
  assign o_owner              = r_owner;
  assign o_disk_read          = r_rd;
  assign o_disk_write         = r_wr;
  assign o_disk_seek          = r_sk;
  assign o_disk_block_address = r_blk;
  assign o_dma_start_address  = r_dma;
  assign o_dma_wordcount      = r_wc;

endmodule

// File: tb/tb_disk_arbiter.sv
// Randomized self-checking bench for disk_arbiter with a transaction-level model
// of arbitration, fault state and a reactive sdhd stand-in.
module tb_disk_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic        ready;
  logic [3:0]  sd_err;
  logic [1:0]  f_cmd [2];
  logic [23:0] f_blk [2];
  logic [15:0] f_dma [2];
  logic [15:0] f_wc  [2];

  logic [1:0]  done, err;
  logic        busy, owner, drd, dwr, dsk;
  logic [23:0] dblk;
  logic [15:0] ddma, dwc;

  int n_checks = 0;
  int n_errors = 0;
  bit m_rr = 1'b0;
  bit m_fault = 1'b0;

  always #5 clk = ~clk;

  disk_arbiter dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req),
    .i_cmd0(f_cmd[0]), .i_cmd1(f_cmd[1]),
    .i_blk0(f_blk[0]), .i_blk1(f_blk[1]),
    .i_dma0(f_dma[0]), .i_dma1(f_dma[1]),
    .i_wc0(f_wc[0]), .i_wc1(f_wc[1]),
    .o_done(done), .o_err(err), .o_busy(busy), .o_owner(owner),
    .o_disk_read(drd), .o_disk_write(dwr), .o_disk_seek(dsk),
    .o_disk_block_address(dblk), .o_dma_start_address(ddma), .o_dma_wordcount(dwc),
    .i_disk_ready(ready), .i_sd_error(sd_err)
  );

  task automatic set_chan(input int ch, input logic [1:0] c);
    f_cmd[ch] = c;
    f_blk[ch] = 24'($urandom);
    f_dma[ch] = 16'($urandom);
    f_wc[ch]  = 16'($urandom);
  endtask

  // Serve one grant: predict winner/result, act as sdhd, check the completion
  task automatic serve(input string name, input bit inj_err);
    bit w, exp_err, disk, got_busy, fbad, multi, finished, o;
    logic [2:0] exp_lvl, seen;
    int phase, cnt, since_busy;
    w       = req[m_rr] ? m_rr : !m_rr;
    o       = !w;
    exp_err = m_fault || (f_cmd[w] == 2'b00) || inj_err;
    disk    = !m_fault && (f_cmd[w] != 2'b00);
    exp_lvl = !disk ? 3'b000 : (f_cmd[w] == 2'b01) ? 3'b100 :
              (f_cmd[w] == 2'b10) ? 3'b010 : 3'b001;
    seen = '0; phase = 0; cnt = $urandom_range(1, 6);
    got_busy = 0; fbad = 0; multi = 0; finished = 0; since_busy = 0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      seen |= {drd, dwr, dsk};
      if (int'(drd) + int'(dwr) + int'(dsk) > 1) multi = 1;
      if (busy) begin
        since_busy++;
        if (!got_busy) begin
          got_busy = 1;
          n_checks++;
          if ({owner, dblk, ddma, dwc} !== {w, f_blk[w], f_dma[w], f_wc[w]}) begin
            n_errors++;
            $display("FAIL %s grant: got owner=%b blk=%h dma=%h wc=%h want owner=%b blk=%h dma=%h wc=%h",
                     name, owner, dblk, ddma, dwc, w, f_blk[w], f_dma[w], f_wc[w]);
          end
        end else if ({dblk, ddma, dwc} !== {f_blk[w], f_dma[w], f_wc[w]}) fbad = 1;
      end
      if (done !== 2'b00) begin
        finished = 1;
        n_checks++;
        if (done !== (2'b01 << w)) begin
          n_errors++;
          $display("FAIL %s done: got %b want %b", name, done, 2'b01 << w);
        end
        n_checks++;
        if (err !== (2'(exp_err) << w)) begin
          n_errors++;
          $display("FAIL %s err: got %b want %b", name, err, 2'(exp_err) << w);
        end
        n_checks++;
        if ({seen, multi} !== {exp_lvl, 1'b0}) begin
          n_errors++;
          $display("FAIL %s disk_cmd rd/wr/sk: got %b multi=%b want %b", name, seen, multi, exp_lvl);
        end
        n_checks++;
        if (fbad) begin
          n_errors++;
          $display("FAIL %s fields_stable: got changed want stable", name);
        end
        if (!disk) begin
          n_checks++;
          if (since_busy > 2) begin
            n_errors++;
            $display("FAIL %s no_disk_latency: got %0d want <=2", name, since_busy);
          end
        end
        req[w] = 1'b0;
        m_rr   = !w;
        if (inj_err) m_fault = 1'b1;
      end else begin
        case (phase)
          0: if (drd | dwr | dsk) begin
               cnt--;
               if (cnt == 0) begin ready = 1'b0; phase = 1; cnt = $urandom_range(1, 6); end
             end
          1: begin
               cnt--;
               if (cnt == 0) begin
                 if (inj_err) sd_err = 4'd4;
                 else         ready  = 1'b1;
                 phase = 2;
               end
             end
          default: ;
        endcase
        if (!req[o]) f_blk[o] = 24'($urandom);
      end
    end
    if (!finished) begin
      n_checks++; n_errors++;
      $display("FAIL %s timeout: got no o_done want done within 300 cycles", name);
    end else begin
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 3'b000) begin
        n_errors++;
        $display("FAIL %s after_done: got done=%b busy=%b want 00/0", name, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; ready = 1'b1; sd_err = '0;
    set_chan(0, 2'b01); set_chan(1, 2'b01);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done, err, busy, owner, drd, dwr, dsk, dblk, ddma, dwc} !== '0) begin
      n_errors++;
      $display("FAIL reset_hold: got nonzero outputs want all 0");
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({done, err, busy, owner, drd, dwr, dsk, dblk, ddma, dwc} !== '0) begin
      n_errors++;
      $display("FAIL reset_idle: got nonzero outputs want all 0");
    end
    m_rr = 0; m_fault = 0;
  endtask

  task automatic test_simultaneous();
    for (int p = 0; p < 2; p++) begin
      set_chan(0, 2'($urandom_range(1, 3)));
      set_chan(1, 2'($urandom_range(1, 3)));
      req = 2'b11;
      n_checks++;
      if (m_rr !== 1'b0) begin
        n_errors++;
        $display("FAIL simul_pref: got rr=%b want 0", m_rr);
      end
      serve("simul_first", 0);
      serve("simul_second", 0);
    end
  endtask

  task automatic test_not_ready();
    bit bad;
    bad = 0;
    ready = 1'b0;
    set_chan(0, 2'b01);
    req = 2'b01;
    repeat (6) begin
      @(negedge clk);
      if ({busy, drd, dwr, dsk, done} !== '0) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL not_ready_idle: got grant want no grant while ready=0");
    end
    ready = 1'b1;
    serve("not_ready_read", 0);
  endtask

  task automatic test_ch0_read();
    f_cmd[0] = 2'b01; f_blk[0] = 24'h000123; f_dma[0] = 16'h1000; f_wc[0] = 16'hFF00;
    req = 2'b01;
    serve("ch0_read", 0);
  endtask

  task automatic test_random();
    logic [1:0] r;
    for (int i = 0; i < 24; i++) begin
      r = 2'($urandom_range(1, 3));
      for (int ch = 0; ch < 2; ch++)
        if (r[ch]) set_chan(ch, ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3)));
      req = r;
      serve("random", 0);
      if (req != 2'b00) serve("random_pair", 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    set_chan(1, 2'b00);
    req = 2'b10;
    serve("ch1_illegal", 0);
  endtask

  task automatic test_reset_mid();
    bit in_busy;
    in_busy = 0;
    set_chan(0, 2'b01);
    req = 2'b01;
    for (int c = 0; c < 50 && !in_busy; c++) begin
      @(negedge clk);
      if (drd) ready = 1'b0;
      else if (busy && !ready) in_busy = 1;
    end
    n_checks++;
    if (!in_busy) begin
      n_errors++;
      $display("FAIL reset_mid_reach: got no busy phase want busy phase");
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({done, err, busy, owner, drd, dwr, dsk, dblk, ddma, dwc} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_async: got nonzero outputs want all 0");
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) ready = 1'b1;
      n_checks++;
      if (done !== 2'b00) begin
        n_errors++;
        $display("FAIL reset_mid_done: got %b want 00", done);
      end
    end
    req = '0; sd_err = '0;
    rst_n = 1'b1;
    m_rr = 0; m_fault = 0;
    @(negedge clk);
  endtask

  task automatic test_sd_error();
    set_chan(1, 2'b01);
    req = 2'b10;
    serve("ch1_sderr", 1);
    set_chan(0, 2'b10);
    req = 2'b01;
    serve("ch0_write_fault", 0);
    set_chan(0, 2'b11); set_chan(1, 2'b01);
    req = 2'b11;
    serve("fault_pair_a", 0);
    serve("fault_pair_b", 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: got no finish want finish before 2ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_simultaneous();
    test_not_ready();
    test_ch0_read();
    test_random();
    test_illegal();
    test_reset_mid();
    test_sd_error();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
